// File: rtl/phv_pkt_aligner.sv
// Pairs processed PHVs with buffered ingress packets in arrival order, rewrites
// the first beat's tdata/tuser from the PHV, or discards the packet on PHV drop.
module phv_pkt_aligner #(
  parameter int DATA_WIDTH     = 256,
  parameter int TUSER_WIDTH    = 128,
  parameter int PHV_WIDTH      = 1124,
  parameter int PKT_DEPTH_BITS = 8,
  parameter int PHV_DEPTH_BITS = 4,
  parameter int PHV_VALID_MODE = 0,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [PHV_WIDTH-1:0]    phv_in,
  input  logic                    phv_in_valid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic                    phv_overflow
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int PKT_W      = DATA_WIDTH + KEEP_WIDTH + TUSER_WIDTH + 1;
  localparam int PHV_E_W    = DATA_WIDTH + TUSER_WIDTH + 1;
  localparam int PKT_DEPTH  = 1 << PKT_DEPTH_BITS;
  localparam int PHV_DEPTH  = 1 << PHV_DEPTH_BITS;
  localparam logic [PKT_DEPTH_BITS-1:0] PKT_PTR_ONE = PKT_DEPTH_BITS'(1);
  localparam logic [PKT_DEPTH_BITS:0]   PKT_FILL_ONE = (PKT_DEPTH_BITS+1)'(1);
  localparam logic [PKT_DEPTH_BITS:0]   PKT_NEAR    = (PKT_DEPTH_BITS+1)'(PKT_DEPTH-1);
  localparam logic [PHV_DEPTH_BITS-1:0] PHV_PTR_ONE = PHV_DEPTH_BITS'(1);
  localparam logic [PHV_DEPTH_BITS:0]   PHV_FILL_ONE = (PHV_DEPTH_BITS+1)'(1);
  localparam logic [PHV_DEPTH_BITS:0]   PHV_FULL    = (PHV_DEPTH_BITS+1)'(PHV_DEPTH);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DROP} state_e;
  state_e state_q, state_d;

  // Packet FIFO: entries are {tlast, tkeep, tuser, tdata}.
  logic [PKT_W-1:0]          pkt_mem [PKT_DEPTH];
  logic [PKT_DEPTH_BITS-1:0] pkt_wr_q, pkt_rd_q;
  logic [PKT_DEPTH_BITS:0]   pkt_fill_q;
  logic                      pkt_push, pkt_pop, pkt_empty;
  logic [PKT_W-1:0]          pkt_head;
  logic [DATA_WIDTH-1:0]     head_data;
  logic [TUSER_WIDTH-1:0]    head_user;
  logic [KEEP_WIDTH-1:0]     head_keep;
  logic                      head_last;

  // PHV FIFO: only {drop, hdr, meta} are kept.
  logic [PHV_E_W-1:0]        phv_mem [PHV_DEPTH];
  logic [PHV_DEPTH_BITS-1:0] phv_wr_q, phv_rd_q;
  logic [PHV_DEPTH_BITS:0]   phv_fill_q;
  logic                      phv_valid_q, phv_wr_en, phv_push, phv_pop, phv_empty, phv_full;
  logic [PHV_E_W-1:0]        phv_head;
  logic                      phv_overflow_q;

  logic [DATA_WIDTH-1:0]  hdr_q, hdr_d;
  logic [TUSER_WIDTH-1:0] meta_q, meta_d;
  logic                   first_q, first_d;
  logic                   tvalid, inc_pkt, inc_drop;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, drop_cnt_q;

  // Both AXI-Stream sides: a beat transfers on a rising clk edge where valid
  // and ready are both high; valid never depends on ready, and the payload
  // is held unchanged while valid is high and ready is low.
  assign pkt_empty     = (pkt_fill_q == '0);
  assign s_axis_tready = (pkt_fill_q < PKT_NEAR);
  assign pkt_push      = s_axis_tvalid & s_axis_tready;
  assign pkt_head      = pkt_mem[pkt_rd_q];
  assign head_data     = pkt_head[DATA_WIDTH-1:0];
  assign head_user     = pkt_head[DATA_WIDTH +: TUSER_WIDTH];
  assign head_keep     = pkt_head[DATA_WIDTH+TUSER_WIDTH +: KEEP_WIDTH];
  assign head_last     = pkt_head[PKT_W-1];

  assign phv_wr_en = (PHV_VALID_MODE == 0) ? (phv_in_valid & ~phv_valid_q) : phv_in_valid;
  assign phv_empty = (phv_fill_q == '0);
  assign phv_full  = (phv_fill_q == PHV_FULL);
  assign phv_push  = phv_wr_en & ~phv_full;
  assign phv_head  = phv_mem[phv_rd_q];

  always_ff @(posedge clk) begin
    if (pkt_push) pkt_mem[pkt_wr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
    if (phv_push) phv_mem[phv_wr_q] <= {phv_in[TUSER_WIDTH], phv_in[PHV_WIDTH-1 -: DATA_WIDTH],
                                        phv_in[TUSER_WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      pkt_wr_q       <= '0;
      pkt_rd_q       <= '0;
      pkt_fill_q     <= '0;
      phv_wr_q       <= '0;
      phv_rd_q       <= '0;
      phv_fill_q     <= '0;
      phv_valid_q    <= 1'b0;
      phv_overflow_q <= 1'b0;
    end else begin
      phv_valid_q <= phv_in_valid;
      if (phv_wr_en && phv_full) phv_overflow_q <= 1'b1;
      if (pkt_push) pkt_wr_q <= pkt_wr_q + PKT_PTR_ONE;
      if (pkt_pop)  pkt_rd_q <= pkt_rd_q + PKT_PTR_ONE;
      case ({pkt_push, pkt_pop})
        2'b10:   pkt_fill_q <= pkt_fill_q + PKT_FILL_ONE;
        2'b01:   pkt_fill_q <= pkt_fill_q - PKT_FILL_ONE;
        default: pkt_fill_q <= pkt_fill_q;
      endcase
      if (phv_push) phv_wr_q <= phv_wr_q + PHV_PTR_ONE;
      if (phv_pop)  phv_rd_q <= phv_rd_q + PHV_PTR_ONE;
      case ({phv_push, phv_pop})
        2'b10:   phv_fill_q <= phv_fill_q + PHV_FILL_ONE;
        2'b01:   phv_fill_q <= phv_fill_q - PHV_FILL_ONE;
        default: phv_fill_q <= phv_fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      meta_q     <= '0;
      first_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      meta_q  <= meta_d;
      first_q <= first_d;
      if (inc_pkt && pkt_cnt_q != '1)   pkt_cnt_q  <= pkt_cnt_q + CNT_ONE;
      if (inc_drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    meta_d   = meta_q;
    first_d  = first_q;
    pkt_pop  = 1'b0;
    phv_pop  = 1'b0;
    inc_pkt  = 1'b0;
    inc_drop = 1'b0;
    tvalid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!pkt_empty && !phv_empty) begin
          phv_pop = 1'b1;
          meta_d  = phv_head[TUSER_WIDTH-1:0];
          hdr_d   = phv_head[TUSER_WIDTH +: DATA_WIDTH];
          first_d = 1'b1;
          state_d = phv_head[PHV_E_W-1] ? ST_DROP : ST_EMIT;
        end
      end
      ST_EMIT: begin
        tvalid = !pkt_empty;
        if (tvalid && m_axis_tready) begin
          pkt_pop = 1'b1;
          first_d = 1'b0;
          if (head_last) begin
            inc_pkt = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (!pkt_empty) begin
          pkt_pop = 1'b1;
          if (head_last) begin
            inc_drop = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = first_q ? hdr_q : head_data;
  assign m_axis_tuser  = first_q ? meta_q : head_user;
  assign m_axis_tkeep  = head_keep;
  assign m_axis_tlast  = head_last;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign phv_overflow  = phv_overflow_q;
endmodule
